max10nios_pio_in: RTL and testbench

Avalon-MM slave input PIO for the MAX10 Nios II system: the read-side counterpart of the single-register output port. It samples an external `WIDTH`-bit input bus through a two-flop synchronizer and exposes the synchronized level to the CPU. It also latches edges into a sticky capture register and raises a level interrupt when a captured edge is unmasked. It sits on the system interconnect next to the output PIOs and drives one Nios IRQ line.

---
 rtl/max10nios_pio_in_if.sv | 26 ++
 rtl/max10nios_pio_in.sv | 101 ++++++++++
 tb/tb_max10nios_pio_in.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/max10nios_pio_in_if.sv
// Avalon-MM slave bus bundle for the input PIO (address, strobes, data).
// Handshake: a write is accepted on any clock where chipselect & ~write_n; reads have no
// strobe, readdata is valid one clock after address is presented, and there are no wait states.
interface max10nios_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/max10nios_pio_in.sv
// Input PIO: 2-flop synchronized level, sticky edge capture, masked level irq.
// Optional MAX10NIOS_PIO_IN_BITCLR_EN: write-1-to-clear EDGECAP instead of clear-all.
module max10nios_pio_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  max10nios_pio_in_if.slave    bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_ok;

  assign wr = bus.chipselect & ~bus.write_n;

  // Upper writedata bits are intentionally ignored.
  assign unused_ok = &{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = s2 & ~s3;
      1:       edge_det = ~s2 & s3;
      default: edge_det = s2 ^ s3;
    endcase
  end

  always_comb begin
    cap_clr = '0;
    if (wr && (bus.address == ADDR_EDGECAP)) begin
`ifdef MAX10NIOS_PIO_IN_BITCLR_EN
      cap_clr = bus.writedata[WIDTH-1:0];
`else
      cap_clr = '1;
`endif
    end
  end

  // Set is ORed in after the clear so a same-cycle edge always survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr && (bus.address == ADDR_IRQMASK)) begin
      irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = s2;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_max10nios_pio_in.sv
// Directed bench for max10nios_pio_in (WIDTH 8, rising-edge capture).
// Expected values are hand-computed; clear-mode expectations follow MAX10NIOS_PIO_IN_BITCLR_EN.
module tb_max10nios_pio_in;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_port;
  logic       irq;
  logic [31:0] rd;
  int n_checks;
  int n_fail;

  max10nios_pio_in_if bus ();

  max10nios_pio_in #(.WIDTH(8), .EDGE_TYPE(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs sampled on the falling edge
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    data = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    in_port        = 8'h00;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;

    // reset state
    wait_cycles(3);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    bus_read(2'd0, rd); check("rst_data", rd, 32'h0);
    bus_read(2'd1, rd); check("rst_reserved", rd, 32'h0);
    bus_read(2'd2, rd); check("rst_irqmask", rd, 32'h0);
    bus_read(2'd3, rd); check("rst_edgecap", rd, 32'h0);
    check("rst_irq_after", {31'b0, irq}, 32'h0);

    // DATA level and read-only behaviour
    in_port = 8'hA5;
    wait_cycles(3);
    bus_read(2'd0, rd); check("data_a5", rd, 32'h0000_00A5);
    bus_write(2'd0, 32'hFF);
    bus_read(2'd0, rd); check("data_ro", rd, 32'h0000_00A5);
    bus_write(2'd1, 32'hFF);
    bus_read(2'd1, rd); check("reserved_ro", rd, 32'h0);
    bus_read(2'd3, rd); check("cap_a5", rd, 32'h0000_00A5);
    check("irq_masked_off", {31'b0, irq}, 32'h0);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, rd); check("cap_clear_all", rd, 32'h0);

    // falling edge on bit0 is not captured
    in_port = 8'hA4;
    wait_cycles(3);
    bus_read(2'd3, rd); check("cap_fall_ignored", rd, 32'h0);
    bus_write(2'd2, 32'h0000_0101);
    bus_read(2'd2, rd); check("irqmask_01", rd, 32'h0000_0001);

    // rising edge on bit0: irq two edges after sampling
    @(negedge clk);
    in_port = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    check("irq_k1_low", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_k2_high", {31'b0, irq}, 32'h1);
    bus_read(2'd3, rd); check("cap_bit0", rd, 32'h0000_0001);

    // clear behaviour with EDGECAP = 0x03
    in_port = 8'hA7;
    wait_cycles(3);
    bus_read(2'd3, rd); check("cap_03", rd, 32'h0000_0003);
`ifdef MAX10NIOS_PIO_IN_BITCLR_EN
    bus_write(2'd3, 32'h01);
    check("irq_after_clr", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check("cap_w1c", rd, 32'h0000_0002);
`else
    bus_write(2'd3, 32'h00);
    check("irq_after_clr", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check("cap_clr_any", rd, 32'h0);
`endif

    // edge and clear on bit1 in the same cycle: set wins
    bus_write(2'd2, 32'h02);
    bus_write(2'd3, 32'hFF);
    in_port = 8'hA5;
    wait_cycles(3);
    bus_read(2'd3, rd); check("cap_pre_setwin", rd, 32'h0);
    @(negedge clk);
    in_port = 8'hA7;
    @(negedge clk);
    bus_write(2'd3, 32'h02);
    check("irq_setwin", {31'b0, irq}, 32'h1);
    bus_read(2'd3, rd); check("cap_setwin", rd, 32'h0000_0002);

    // async reset with irq high and EDGECAP full
    bus_write(2'd2, 32'hFF);
    in_port = 8'h00;
    wait_cycles(3);
    in_port = 8'hFF;
    wait_cycles(3);
    bus_read(2'd3, rd); check("cap_ff", rd, 32'h0000_00FF);
    check("irq_ff", {31'b0, irq}, 32'h1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_irq", {31'b0, irq}, 32'h0);
    check("async_readdata", bus.readdata, 32'h0);
    wait_cycles(2);
    reset_n = 1'b1;
    bus_read(2'd2, rd); check("post_rst_mask", rd, 32'h0);
    wait_cycles(3);
    bus_read(2'd3, rd); check("post_rst_cap_high_in", rd, 32'h0000_00FF);
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd0, rd); check("post_rst_data", rd, 32'h0000_00FF);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
